ev_enq_arb: RTL and testbench



---
 rtl/pdes_pkg.sv | 16 +
 rtl/ev_min_tree.sv | 24 ++
 rtl/ev_enq_arb.sv | 130 +++++++++++++
 tb/tb_ev_enq_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdes_pkg.sv
// Shared PDES engine types: event word layout and timestamp access.
// Used by the cores, the enqueue arbiter, prio_q and the GVT unit.
package pdes_pkg;

    localparam int DWIDTH   = 32;
    localparam int TS_WIDTH = 16;

    typedef logic [DWIDTH-1:0]   ev_word_t;
    typedef logic [TS_WIDTH-1:0] ev_ts_t;

    // Timestamp lives in the low bits of the event word.
    function automatic ev_ts_t ev_ts(input ev_word_t w);
        return w[TS_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ev_min_tree.sv
// Combinational minimum over N (valid, timestamp) pairs.
// Invalid entries read as all-ones, so an empty set yields all-ones.
module ev_min_tree #(
    parameter int N        = 5,
    parameter int TS_WIDTH = 16
) (
    input  logic [N-1:0]          vld,
    input  logic [N*TS_WIDTH-1:0] ts,
    output logic                  any_vld,
    output logic [TS_WIDTH-1:0]   min_ts
);

    // Reduce all valid timestamps to their unsigned minimum.
    always_comb begin
        any_vld = |vld;
        min_ts  = '1;
        for (int i = 0; i < N; i++) begin
            if (vld[i] && (ts[i*TS_WIDTH +: TS_WIDTH] < min_ts)) begin
                min_ts = ts[i*TS_WIDTH +: TS_WIDTH];
            end
        end
    end

endmodule

// File: rtl/ev_enq_arb.sv
// Collects core events into per-core hold slots and feeds prio_q
// round-robin through one output register; tracks in-flight min ts.
module ev_enq_arb #(
    parameter int NUM_CORES = 4,
    parameter int DWIDTH    = pdes_pkg::DWIDTH,
    parameter int TS_WIDTH  = pdes_pkg::TS_WIDTH,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_ev_valid,
    input  logic [NUM_CORES*DWIDTH-1:0] core_ev_data,
    output logic [NUM_CORES-1:0]        core_ev_ready,
    input  logic                        q_full,
    output logic                        q_enq,
    output logic [DWIDTH-1:0]           q_data,
    output logic                        pend_vld,
    output logic [TS_WIDTH-1:0]         pend_min_ts,
    output logic [CNT_WIDTH-1:0]        enq_count
);

    import pdes_pkg::*;

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int NT    = NUM_CORES + 1;

    logic [NUM_CORES-1:0] hold_vld_q, hold_vld_d;
    logic [DWIDTH-1:0]    hold_data_q [NUM_CORES];
    logic [DWIDTH-1:0]    hold_data_d [NUM_CORES];
    logic                 out_vld_q, out_vld_d;
    logic [DWIDTH-1:0]    out_data_q, out_data_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] enq_count_q, enq_count_d;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic                 load_ok;
    int                   scan_idx;

    logic [NT-1:0]          tree_vld;
    logic [NT*TS_WIDTH-1:0] tree_ts;

    assign core_ev_ready = ~hold_vld_q;
    assign q_enq         = out_vld_q && !q_full;
    assign q_data        = out_data_q;
    assign enq_count     = enq_count_q;
    assign load_ok       = !out_vld_q || q_enq;

    // Round-robin search for the first occupied slot from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!grant_found && hold_vld_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Next state: captures, grant into output, drain and count.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        enq_count_d = enq_count_q + CNT_WIDTH'(q_enq);
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_ev_valid[i] && !hold_vld_q[i]) begin
                hold_vld_d[i]  = 1'b1;
                hold_data_d[i] = core_ev_data[i*DWIDTH +: DWIDTH];
            end
        end
        if (grant_found && load_ok) begin
            out_vld_d             = 1'b1;
            out_data_d            = hold_data_q[grant_idx];
            hold_vld_d[grant_idx] = 1'b0;
            if (grant_idx == PTR_W'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end else if (q_enq) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q  <= '0;
            hold_data_q <= '{default: '0};
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
            enq_count_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            enq_count_q <= enq_count_d;
        end
    end

    // Gather every held event and the output register for the min.
    always_comb begin
        tree_vld = {out_vld_q, hold_vld_q};
        tree_ts  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            tree_ts[i*TS_WIDTH +: TS_WIDTH] = hold_data_q[i][TS_WIDTH-1:0];
        end
        tree_ts[NUM_CORES*TS_WIDTH +: TS_WIDTH] = out_data_q[TS_WIDTH-1:0];
    end

    ev_min_tree #(
        .N       (NT),
        .TS_WIDTH(TS_WIDTH)
    ) u_min (
        .vld    (tree_vld),
        .ts     (tree_ts),
        .any_vld(pend_vld),
        .min_ts (pend_min_ts)
    );

endmodule

// File: tb/tb_ev_enq_arb.sv
// Bench for ev_enq_arb: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the queue feeder.
module tb_ev_enq_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cv;
    logic [DW-1:0]   cd [N];
    logic [N*DW-1:0] core_ev_data;
    logic [N-1:0]    core_ev_ready;
    logic            qf;
    logic            q_enq;
    logic [DW-1:0]   q_data;
    logic            pend_vld;
    logic [TW-1:0]   pend_min_ts;
    logic [CW-1:0]   enq_count;

    int checks   = 0;
    int failures = 0;

    // model state: per-core slot, output register, pointer, counter
    bit          mh_v [N];
    logic [31:0] mh_d [N];
    bit          mo_v;
    logic [31:0] mo_d;
    int          mptr;
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    always_comb begin
        core_ev_data = '0;
        for (int i = 0; i < N; i++) core_ev_data[i*DW +: DW] = cd[i];
    end

    ev_enq_arb #(
        .NUM_CORES(N), .DWIDTH(DW), .TS_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ev_valid(cv),
        .core_ev_data (core_ev_data),
        .core_ev_ready(core_ev_ready),
        .q_full       (qf),
        .q_enq        (q_enq),
        .q_data       (q_data),
        .pend_vld     (pend_vld),
        .pend_min_ts  (pend_min_ts),
        .enq_count    (enq_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model one rising edge from current inputs and model state.
    task automatic model_edge();
        bit enq;
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mh_v[i] = 0;
                mh_d[i] = '0;
            end
            mo_v = 0; mo_d = '0; mptr = 0; mcnt = '0;
            return;
        end
        enq = mo_v && !qf;
        g = -1;
        if (!mo_v || enq) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mh_v[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        if (enq) mcnt = mcnt + 1;
        if (g >= 0) begin
            mo_v = 1; mo_d = mh_d[g]; mh_v[g] = 0; mptr = (g + 1) % N;
        end else if (enq) begin
            mo_v = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (cv[i] && !(mh_v[i] || (g == i))) begin
                mh_v[i] = 1; mh_d[i] = cd[i];
            end
        end
    endtask

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !mh_v[i];
        return r;
    endfunction

    function automatic logic [TW-1:0] m_min();
        logic [TW-1:0] m = '1;
        for (int i = 0; i < N; i++) if (mh_v[i] && mh_d[i][TW-1:0] < m) m = mh_d[i][TW-1:0];
        if (mo_v && mo_d[TW-1:0] < m) m = mo_d[TW-1:0];
        return m;
    endfunction

    task automatic check_all();
        bit any;
        any = mo_v;
        for (int i = 0; i < N; i++) any |= mh_v[i];
        chk("ready", 64'(core_ev_ready), 64'(m_ready()));
        chk("q_enq", 64'(q_enq), 64'(mo_v && !qf));
        if (mo_v) chk("q_data", 64'(q_data), 64'(mo_d));
        chk("pend_vld", 64'(pend_vld), 64'(any));
        chk("pend_min_ts", 64'(pend_min_ts), 64'(m_min()));
        chk("enq_count", 64'(enq_count), 64'(mcnt));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_bp [4];
        logic [N-1:0] acc;
        int seq;
        rst = 1'b1; qf = 1'b0; cv = '0;
        for (int i = 0; i < N; i++) cd[i] = '0;
        do_reset();
        chk("rst_ready", 64'(core_ev_ready), 64'hF);
        chk("rst_min", 64'(pend_min_ts), 64'hFFFF);

        // single event on core 2
        cv[2] = 1'b1; cd[2] = 32'd37;
        tick();
        cv[2] = 1'b0;
        chk("single_ready2", 64'(core_ev_ready[2]), 64'd0);
        tick();
        chk("single_enq", 64'(q_enq), 64'd1);
        chk("single_data", 64'(q_data), 64'd37);
        tick();
        chk("single_cnt", 64'(enq_count), 64'd1);
        chk("single_pend", 64'(pend_vld), 64'd0);

        // fairness with all cores streaming
        do_reset();
        for (int i = 0; i < N; i++) cd[i] = 32'((i + 1) * 10);
        cv = '1;
        tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("fair_enq", 64'(q_enq), 64'd1);
            chk("fair_data", 64'(q_data), 64'(((j % 4) + 1) * 10));
        end
        cv = '0;
        for (int j = 0; j < 8; j++) tick();

        // backpressure
        do_reset();
        qf = 1'b1;
        cd[0] = 32'd5; cd[1] = 32'd9; cd[2] = 32'd2; cd[3] = 32'd7;
        exp_bp[0] = 32'd5; exp_bp[1] = 32'd9; exp_bp[2] = 32'd2; exp_bp[3] = 32'd7;
        cv = '1;
        tick();
        cv = '0;
        tick(); tick(); tick();
        chk("bp_ready", 64'(core_ev_ready), 64'b0001);
        chk("bp_min", 64'(pend_min_ts), 64'd2);
        chk("bp_hold", 64'(q_enq), 64'd0);
        qf = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_enq", 64'(q_enq), 64'd1);
            chk("bp_data", 64'(q_data), 64'(exp_bp[j]));
            tick();
        end
        chk("bp_cnt", 64'(enq_count), 64'd4);
        chk("bp_empty", 64'(pend_vld), 64'd0);

        // min tracking
        do_reset();
        qf = 1'b1;
        cv[0] = 1'b1; cd[0] = 32'd100;
        tick();
        cv[0] = 1'b0;
        tick();
        chk("min_100", 64'(pend_min_ts), 64'd100);
        cv[1] = 1'b1; cd[1] = 32'd60;
        tick();
        cv[1] = 1'b0;
        chk("min_60", 64'(pend_min_ts), 64'd60);
        qf = 1'b0;
        for (int n = 0; n < 10 && pend_vld; n++) tick();
        chk("min_drain_vld", 64'(pend_vld), 64'd0);
        chk("min_drain_ts", 64'(pend_min_ts), 64'hFFFF);

        // reset mid-flight, count nonzero beforehand
        qf = 1'b1;
        cd[0] = 32'd11; cd[1] = 32'd12; cd[2] = 32'd13;
        cv = 4'b0111;
        tick();
        cv = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_pend", 64'(pend_vld), 64'd0);
        chk("mid_ready", 64'(core_ev_ready), 64'hF);
        chk("mid_enq", 64'(q_enq), 64'd0);
        chk("mid_cnt", 64'(enq_count), 64'd0);
        qf = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("mid_noenq", 64'(q_enq), 64'd0);
        end

        // counter wrap
        qf = 1'b1;
        cv[3] = 1'b1; cd[3] = 32'd3;
        tick();
        cv[3] = 1'b0;
        tick();
        force dut.enq_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.enq_count_q;
        mcnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", 64'(enq_count), 64'hFFFF_FFFF);
        qf = 1'b0;
        #1;
        chk("wrap_enq", 64'(q_enq), 64'd1);
        tick();
        chk("wrap_cnt", 64'(enq_count), 64'd0);

        // random traffic against the model
        do_reset();
        seq = 0;
        cv = '0;
        for (int c = 0; c < 400; c++) begin
            qf = ($urandom_range(0, 2) == 0);
            acc = cv & m_ready();
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) cv[i] = 1'b0;
                if (!cv[i] && ($urandom_range(0, 1) == 1)) begin
                    seq++;
                    cv[i] = 1'b1;
                    cd[i] = {8'(i), 8'(seq), 16'($urandom)};
                end
            end
        end
        cv = '0; qf = 1'b0;
        for (int n = 0; n < 12 && pend_vld; n++) tick();
        chk("rand_drain", 64'(pend_vld), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
